// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM states, default geometry and tag-width helper for the cache controller.
package cache_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_INDEX_W = 2;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, RESPOND} state_e;
  function automatic int tag_w(input int addr_w, input int index_w);
    return addr_w - index_w;
  endfunction
endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: direct-mapped valid/dirty/tag/data store with combinational lookup and one write port.
module cache_line_array import cache_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int INDEX_W = DEF_INDEX_W,
  localparam int TAG_W = tag_w(ADDR_W, INDEX_W)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  output logic               hit,
  output logic               victim_dirty,
  output logic [TAG_W-1:0]   victim_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               we,
  input  logic               wr_dirty,
  input  logic               clr_dirty,
  input  logic [DATA_W-1:0]  wr_data
);
  localparam int LINES = 2 ** INDEX_W;
  logic [LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [LINES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [LINES-1:0][DATA_W-1:0] data_q, data_d;
  assign hit = valid_q[index] && tag_q[index] == tag;
  assign victim_dirty = valid_q[index] && dirty_q[index];
  assign victim_tag = tag_q[index];
  assign rd_data = data_q[index];
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d = tag_q;
    data_d = data_q;
    if (clr_dirty) dirty_d[index] = 1'b0;
    if (we) begin
      valid_d[index] = 1'b1;
      dirty_d[index] = wr_dirty;
      tag_d[index] = tag;
      data_d[index] = wr_data;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      tag_q <= '0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q <= tag_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped write-back/write-allocate cache FSM with req/ack backing-memory port
// and saturating hit/miss statistics.
module cache_controller import cache_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_dataIn,
  output logic [DATA_W-1:0] cpu_dataOut,
  output logic              cpu_ready,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataOut,
  input  logic [DATA_W-1:0] mem_dataIn,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int TAG_W = tag_w(ADDR_W, INDEX_W);
  state_e state_q, state_d;
  logic req_write_q, req_write_d, cpu_hit_q, cpu_hit_d, mem_req_q, mem_req_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d, mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d, cpu_data_q, cpu_data_d, mem_data_q, mem_data_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic hit, victim_dirty, we, wr_dirty, clr_dirty;
  logic [TAG_W-1:0] victim_tag;
  logic [DATA_W-1:0] rd_data, wr_data;
  cache_line_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W)) u_lines (
    .clock(clock), .reset_n(reset_n),
    .index(req_addr_q[INDEX_W-1:0]), .tag(req_addr_q[ADDR_W-1:INDEX_W]),
    .hit(hit), .victim_dirty(victim_dirty), .victim_tag(victim_tag), .rd_data(rd_data),
    .we(we), .wr_dirty(wr_dirty), .clr_dirty(clr_dirty), .wr_data(wr_data)
  );
  assign cpu_dataOut = cpu_data_q;
  assign cpu_ready = state_q == RESPOND;
  assign cpu_hit = cpu_hit_q;
  assign mem_req = mem_req_q;
  assign mem_write = mem_write_q;
  assign mem_address = mem_addr_q;
  assign mem_dataOut = mem_data_q;
  assign hit_count = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  always_comb begin
    state_d = state_q;
    req_write_d = req_write_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    cpu_data_d = cpu_data_q;
    cpu_hit_d = cpu_hit_q;
    mem_req_d = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    hit_cnt_d = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    we = 1'b0;
    wr_dirty = 1'b1;
    clr_dirty = 1'b0;
    wr_data = req_data_q;
    case (state_q)
      IDLE: if (cpu_req) begin
        state_d = COMPARE;
        req_write_d = cpu_write;
        req_addr_d = cpu_address;
        req_data_d = cpu_dataIn;
      end
      COMPARE: if (hit) begin
        state_d = RESPOND;
        we = req_write_q;
        cpu_data_d = req_write_q ? cpu_data_q : rd_data;
        cpu_hit_d = 1'b1;
        hit_cnt_d = hit_cnt_q + CNT_W'(!(&hit_cnt_q));
      end else begin
        state_d = victim_dirty ? WRITEBACK : ALLOCATE;
        mem_req_d = 1'b1;
        mem_write_d = victim_dirty;
        mem_addr_d = victim_dirty ? {victim_tag, req_addr_q[INDEX_W-1:0]} : req_addr_q;
        mem_data_d = victim_dirty ? rd_data : mem_data_q;
      end
      WRITEBACK: if (mem_ack) begin
        state_d = ALLOCATE;
        clr_dirty = 1'b1;
        mem_write_d = 1'b0;
        mem_addr_d = req_addr_q;
      end
      // A write miss stores the CPU word over the fill in one step, leaving the line dirty.
      ALLOCATE: if (mem_ack) begin
        state_d = RESPOND;
        we = 1'b1;
        wr_dirty = req_write_q;
        wr_data = req_write_q ? req_data_q : mem_dataIn;
        mem_req_d = 1'b0;
        cpu_data_d = req_write_q ? cpu_data_q : mem_dataIn;
        cpu_hit_d = 1'b0;
        miss_cnt_d = miss_cnt_q + CNT_W'(!(&miss_cnt_q));
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_write_q <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      cpu_data_q <= '0;
      cpu_hit_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      req_write_q <= req_write_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      cpu_data_q <= cpu_data_d;
      cpu_hit_q <= cpu_hit_d;
      mem_req_q <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: table-driven requests against a waitstate-programmable memory model,
// scoreboarded responses, plus reset-during-writeback and counter saturation sequences.
module tb_cache_controller;
  logic clock = 1'b0, reset_n = 1'b0;
  logic cpu_req = 1'b0, cpu_write = 1'b0;
  logic [7:0] cpu_address = '0, cpu_dataIn = '0, cpu_dataOut, mem_address, mem_dataOut, mem_dataIn;
  logic cpu_ready, cpu_hit, mem_req, mem_write, mem_ack;
  logic [7:0] hit_count, miss_count;

  cache_controller dut (
    .clock(clock), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_dataIn(cpu_dataIn), .cpu_dataOut(cpu_dataOut),
    .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .mem_req(mem_req), .mem_write(mem_write),
    .mem_address(mem_address), .mem_dataOut(mem_dataOut), .mem_dataIn(mem_dataIn),
    .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] ed;
    logic eh;
    int lat;
    int issue;
  } sb_t;
  typedef struct {
    logic w;
    logic [7:0] a, d;
  } memop_t;
  typedef struct {
    logic w;
    logic [7:0] a, d, ed;
    logic eh;
    int stall, lat, nm;
    logic [7:0] wa, wd, fa;
  } vec_t;

  sb_t sb[$];
  memop_t mlog[$];
  vec_t v[13];
  int n_cmp = 0, n_bad = 0, cyc = 0, pulses = 0, reqs = 0;
  int stall = 0, wcnt = 0;
  logic [7:0] mem [256];
  logic pend = 1'b0, p_write = 1'b0, stab_on = 1'b1;
  logic [7:0] p_addr = '0, p_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Backing memory: acks after `stall` waiting cycles, commits write-backs on the ack edge.
  assign mem_ack = mem_req && wcnt == stall;
  assign mem_dataIn = mem[mem_address];
  always @(posedge clock) begin
    cyc <= cyc + 1;
    wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
    if (mem_req && mem_ack) begin
      if (mem_write) mem[mem_address] <= mem_dataOut;
      mlog.push_back('{mem_write, mem_address, mem_dataOut});
    end
  end

  always @(negedge clock) begin
    if (reset_n && cpu_ready) begin
      pulses <= pulses + 1;
      if (sb.size() == 0) chk("spurious_ready", 32'd1, 32'd0);
      else begin
        chk("rd_data", cpu_dataOut, sb[0].ed);
        chk("cpu_hit", cpu_hit, sb[0].eh);
        chk("latency", cyc - sb[0].issue, sb[0].lat);
        sb.delete(0);
      end
    end
    if (pend && reset_n && stab_on) begin
      chk("mem_req_hold", mem_req, 1);
      chk("mem_addr_hold", mem_address, p_addr);
      chk("mem_write_hold", mem_write, p_write);
      if (p_write) chk("mem_data_hold", mem_dataOut, p_data);
    end
    pend <= reset_n && mem_req && !mem_ack;
    p_addr <= mem_address;
    p_write <= mem_write;
    p_data <= mem_dataOut;
  end

  task automatic do_req(input logic w, input logic [7:0] a, d, ed, input logic eh, input int lat);
    @(negedge clock);
    cpu_req = 1'b1;
    cpu_write = w;
    cpu_address = a;
    cpu_dataIn = d;
    sb.push_back('{ed, eh, lat, cyc});
    reqs++;
    @(posedge clock);
    #1;
    cpu_req = 1'b0;
    cpu_write = ~w;
    cpu_address = ~a;
    cpu_dataIn = ~d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (cpu_ready) return;
    end
    chk("ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5F;
    v[0]  = '{1'b0, 8'h05, 8'h00, 8'h5A, 1'b0, 0, 3, 1, 8'h00, 8'h00, 8'h05};
    v[1]  = '{1'b0, 8'h05, 8'h00, 8'h5A, 1'b1, 0, 2, 0, 8'h00, 8'h00, 8'h00};
    v[2]  = '{1'b1, 8'h05, 8'hC3, 8'h5A, 1'b1, 0, 2, 0, 8'h00, 8'h00, 8'h00};
    v[3]  = '{1'b0, 8'h09, 8'h00, 8'h56, 1'b0, 0, 4, 2, 8'h05, 8'hC3, 8'h09};
    v[4]  = '{1'b0, 8'h05, 8'h00, 8'hC3, 1'b0, 3, 6, 1, 8'h00, 8'h00, 8'h05};
    v[5]  = '{1'b1, 8'h0A, 8'h77, 8'hC3, 1'b0, 0, 3, 1, 8'h00, 8'h00, 8'h0A};
    v[6]  = '{1'b0, 8'h0A, 8'h00, 8'h77, 1'b1, 0, 2, 0, 8'h00, 8'h00, 8'h00};
    v[7]  = '{1'b0, 8'h0E, 8'h00, 8'h51, 1'b0, 0, 4, 2, 8'h0A, 8'h77, 8'h0E};
    v[8]  = '{1'b1, 8'h0E, 8'h11, 8'h51, 1'b1, 0, 2, 0, 8'h00, 8'h00, 8'h00};
    v[9]  = '{1'b0, 8'h02, 8'h00, 8'h5D, 1'b0, 2, 8, 2, 8'h0E, 8'h11, 8'h02};
    v[10] = '{1'b0, 8'h0E, 8'h00, 8'h11, 1'b0, 1, 4, 1, 8'h00, 8'h00, 8'h0E};
    v[11] = '{1'b0, 8'h00, 8'h00, 8'h5F, 1'b0, 0, 3, 1, 8'h00, 8'h00, 8'h00};
    v[12] = '{1'b0, 8'h00, 8'h00, 8'h5F, 1'b1, 0, 2, 0, 8'h00, 8'h00, 8'h00};

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    chk("rst_dataOut", cpu_dataOut, 0);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_hit", cpu_hit, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_counts", {hit_count, miss_count}, 0);

    foreach (v[i]) begin
      stall = v[i].stall;
      mlog.delete();
      do_req(v[i].w, v[i].a, v[i].d, v[i].ed, v[i].eh, v[i].lat);
      chk($sformatf("memops_%0d", i), mlog.size(), v[i].nm);
      if (mlog.size() == 2 && v[i].nm == 2) begin
        chk("wb_write", mlog[0].w, 1);
        chk("wb_addr", mlog[0].a, v[i].wa);
        chk("wb_data", mlog[0].d, v[i].wd);
        chk("fill_write", mlog[1].w, 0);
        chk("fill_addr", mlog[1].a, v[i].fa);
      end
      if (mlog.size() == 1 && v[i].nm == 1) begin
        chk("fill_write", mlog[0].w, 0);
        chk("fill_addr", mlog[0].a, v[i].fa);
      end
    end
    chk("hit_count_tbl", hit_count, 5);
    chk("miss_count_tbl", miss_count, 8);

    // Dirty the line at index 1, then reset while its write-back is stalled.
    stall = 0;
    do_req(1'b1, 8'h05, 8'hAA, 8'h5F, 1'b1, 2);
    stall = 5;
    stab_on = 1'b0;
    @(negedge clock);
    cpu_req = 1'b1;
    cpu_write = 1'b0;
    cpu_address = 8'h09;
    @(posedge clock);
    #1 cpu_req = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clock);
    chk("wbr_mem_req", mem_req, 1);
    chk("wbr_mem_write", mem_write, 1);
    chk("wbr_mem_addr", mem_address, 8'h05);
    chk("wbr_mem_data", mem_dataOut, 8'hAA);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_mem_write", mem_write, 0);
    chk("abort_mem_addr", mem_address, 0);
    chk("abort_counts", {hit_count, miss_count}, 0);
    chk("abort_ready", cpu_ready, 0);
    @(negedge clock);
    reset_n = 1'b1;
    stall = 0;
    mlog.delete();
    @(negedge clock);
    stab_on = 1'b1;
    do_req(1'b0, 8'h05, 8'h00, 8'hC3, 1'b0, 3);
    chk("post_rst_memops", mlog.size(), 1);
    chk("post_rst_miss", miss_count, 1);

    // Conflicting reads on index 0 never hit; the miss counter must stop at all-ones.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      a = i[0] ? 8'h04 : 8'h00;
      do_req(1'b0, a, 8'h00, a ^ 8'h5F, 1'b0, 3);
    end
    chk("miss_saturate", miss_count, 8'hFF);
    chk("hit_after_sat", hit_count, 0);
    repeat (3) @(negedge clock);
    chk("sb_empty", sb.size(), 0);
    chk("ready_pulses", pulses, reqs);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
